// File: rtl/sensor_debounce_sampler_if.sv
// Snapshot handshake between the debounce sampler (master) and its consumer (slave).
interface sensor_debounce_sampler_if;
  logic [5:0] snap_data;
  logic       snap_valid;
  logic       snap_ready;

  modport master (output snap_data, output snap_valid, input snap_ready);
  modport slave  (input snap_data, input snap_valid, output snap_ready);
endinterface

// File: rtl/sensor_debounce_sampler.sv
// Six-input switch debouncer with a snapshot handshake and sticky overrun/chatter flags.
// Define SENSOR_CHATTER_DETECT_EN to build the per-bit chatter (aborted debounce) detector.
module sensor_debounce_sampler #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CHATTER_LIMIT   = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [5:0]                       sensor_raw,
  output logic [5:0]                       sensor_stable,
  output logic                             change_pulse,
  output logic                             overrun,
  input  logic                             flag_clear,
  output logic [5:0]                       chatter,
  sensor_debounce_sampler_if.master        snap
);

  localparam int unsigned NB       = 6;
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || CHATTER_LIMIT < 1 || CHATTER_LIMIT > 255) begin : g_bad_params
    $error("sensor_debounce_sampler: parameter out of legal range");
  end

  logic [NB-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0] stable_q, stable_d;
  logic          pulse_q, pulse_d;
  logic [NB-1:0] snap_data_q, snap_data_d;
  logic          snap_valid_q, snap_valid_d;
  logic          overrun_q, overrun_d;
  logic [NB-1:0] commit;
  logic          commit_any;

  always_comb begin
    sync1_d = sensor_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef SENSOR_CHATTER_DETECT_EN
  localparam logic [7:0] CHAT_LIM = 8'(CHATTER_LIMIT);
  logic [NB-1:0] chat_set;
`endif

  for (genvar gi = 0; gi < NB; gi++) begin : g_bit
    logic [15:0] cnt_q, cnt_d;
    logic        diff;
    logic        commit_b;

    // A commit needs DEBOUNCE_CYCLES consecutive differing samples: counts 0..CNT_LAST, then load.
    always_comb begin
      diff     = sync2_q[gi] ^ stable_q[gi];
      commit_b = 1'b0;
      cnt_d    = '0;
      if (diff) begin
        if (cnt_q >= CNT_LAST) begin
          commit_b = 1'b1;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign commit[gi] = commit_b;

`ifdef SENSOR_CHATTER_DETECT_EN
    logic [7:0] abort_q, abort_d;
    logic       chat_set_b;

    // An abort is a debounce run that ended (input returned) before reaching commit.
    always_comb begin
      abort_d    = abort_q;
      chat_set_b = 1'b0;
      if (commit_b) begin
        abort_d = '0;
      end else if (!diff && cnt_q != '0) begin
        if (abort_q != 8'hFF) abort_d = abort_q + 8'd1;
        chat_set_b = (abort_d >= CHAT_LIM);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) abort_q <= '0;
      else        abort_q <= abort_d;
    end

    assign chat_set[gi] = chat_set_b;
`endif
  end

  always_comb begin
    commit_any   = |commit;
    stable_d     = (stable_q & ~commit) | (sync2_q & commit);
    pulse_d      = commit_any;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;
    if (commit_any) begin
      snap_data_d  = stable_d;
      snap_valid_d = 1'b1;
    end else if (snap_valid_q && snap.snap_ready) begin
      snap_valid_d = 1'b0;
    end
    // Set beats clear; an accept on the commit edge is not an overwrite.
    overrun_d = (commit_any && snap_valid_q && !snap.snap_ready) || (overrun_q && !flag_clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q     <= '0;
      pulse_q      <= 1'b0;
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      stable_q     <= stable_d;
      pulse_q      <= pulse_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef SENSOR_CHATTER_DETECT_EN
  logic [NB-1:0] chatter_q, chatter_d;

  always_comb begin
    chatter_d = chat_set | (chatter_q & ~{NB{flag_clear}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chatter_q <= '0;
    else        chatter_q <= chatter_d;
  end

  assign chatter = chatter_q;
`else
  assign chatter = '0;
`endif

  assign sensor_stable   = stable_q;
  assign change_pulse    = pulse_q;
  assign overrun         = overrun_q;
  assign snap.snap_data  = snap_data_q;
  assign snap.snap_valid = snap_valid_q;

endmodule

// File: tb/tb_sensor_debounce_sampler.sv
// Bench for sensor_debounce_sampler: directed vector table, corner sequences, and a
// randomized run against a window-based reference model. Honours SENSOR_CHATTER_DETECT_EN.
module tb_sensor_debounce_sampler;
  localparam int D  = 4;
  localparam int CL = 2;
`ifdef SENSOR_CHATTER_DETECT_EN
  localparam logic [5:0] EXP_CHAT = 6'h20;
`else
  localparam logic [5:0] EXP_CHAT = 6'h00;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] raw = '0;
  logic       fclr = 1'b0;
  logic [5:0] stable, chat;
  logic       pulse, over;

  sensor_debounce_sampler_if sif ();

  sensor_debounce_sampler #(.DEBOUNCE_CYCLES(D), .CHATTER_LIMIT(CL)) dut (
    .clk(clk), .rst_n(rst_n), .sensor_raw(raw), .sensor_stable(stable),
    .change_pulse(pulse), .overrun(over), .flag_clear(fclr), .chatter(chat),
    .snap(sif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [5:0] raw;
    logic       rdy;
    logic [5:0] st;
    logic       p;
    logic       v;
    logic [5:0] dat;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [20:0] outs();
    return {stable, pulse, sif.snap_valid, sif.snap_data, over, chat};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; raw = '0; fclr = 1'b0; sif.snap_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_pulse(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pulse && n < max);
  endtask

  // Reference model: a bit commits when its last D synchronized samples all differ from stable.
  logic [5:0] m_r1, m_r2, m_stable, m_data, m_chat;
  logic       m_pulse, m_valid, m_over;
  logic [5:0] m_hist[$];
  int         m_abort[6];
  bit         m_pdiff[6];

  task automatic model_reset();
    m_r1 = '0; m_r2 = '0; m_stable = '0; m_data = '0; m_chat = '0;
    m_pulse = 0; m_valid = 0; m_over = 0;
    m_hist.delete();
    for (int i = 0; i < 6; i++) begin m_abort[i] = 0; m_pdiff[i] = 0; end
  endtask

  task automatic model_edge(input logic [5:0] r, input logic rdy, input logic fc);
    logic [5:0] s, commit, cset;
    bit all;
    s = m_r2;
    m_hist.push_back(s);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    commit = '0; cset = '0;
    for (int i = 0; i < 6; i++) begin
      all = (m_hist.size() == D);
      foreach (m_hist[k]) if (m_hist[k][i] == m_stable[i]) all = 0;
      commit[i] = all;
      if (all) begin
        m_abort[i] = 0; m_pdiff[i] = 0;
      end else begin
        if (s[i] == m_stable[i] && m_pdiff[i]) begin
          if (m_abort[i] < 255) m_abort[i]++;
          if (m_abort[i] >= CL) cset[i] = 1'b1;
        end
        m_pdiff[i] = (s[i] != m_stable[i]);
      end
    end
    m_over = ((commit != 0) && m_valid && !rdy) || (m_over && !fc);
    m_stable = m_stable ^ commit;
    m_pulse = (commit != 0);
    if (commit != 0) begin m_valid = 1; m_data = m_stable; end
    else if (m_valid && rdy) m_valid = 0;
`ifdef SENSOR_CHATTER_DETECT_EN
    m_chat = cset | (fc ? 6'h00 : m_chat);
`else
    m_chat = cset & 6'h00;
`endif
    m_r2 = m_r1; m_r1 = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    logic rdy_r, fc_r;
    logic [5:0] raw_r;

    for (int k = 0; k < 5; k++) tbl[k] = '{6'h07, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00};
    tbl[5] = '{6'h07, 1'b0, 6'h07, 1'b1, 1'b1, 6'h07};
    tbl[6] = '{6'h07, 1'b0, 6'h07, 1'b0, 1'b1, 6'h07};
    tbl[7] = '{6'h07, 1'b1, 6'h07, 1'b0, 1'b0, 6'h07};
    for (int k = 8; k < 11; k++)  tbl[k] = '{6'h0F, 1'b0, 6'h07, 1'b0, 1'b0, 6'h07};
    for (int k = 11; k < 16; k++) tbl[k] = '{6'h07, 1'b0, 6'h07, 1'b0, 1'b0, 6'h07};

    sif.snap_ready = 1'b0;
    #1;
    check("reset_state", 32'(outs()), 32'h0);
    do_reset();

    // Latency, hold, accept, and a 3-cycle glitch on bit 3.
    for (int k = 0; k < 16; k++) begin
      raw = tbl[k].raw; sif.snap_ready = tbl[k].rdy;
      tick();
      $display("vec %0d raw=%h rdy=%b -> stable=%h pulse=%b valid=%b data=%h", k, raw, sif.snap_ready,
               stable, pulse, sif.snap_valid, sif.snap_data);
      check($sformatf("vec%0d", k), 32'({stable, pulse, sif.snap_valid, sif.snap_data, over}),
            32'({tbl[k].st, tbl[k].p, tbl[k].v, tbl[k].dat, 1'b0}));
    end

    // Two commits with no acceptance set overrun; flag_clear drops it.
    do_reset();
    raw = 6'h01;
    wait_pulse(20, n);
    check("latency_first", 32'(n), 32'(D + 2));
    check("snap_first", 32'({sif.snap_valid, sif.snap_data, over}), 32'({1'b1, 6'h01, 1'b0}));
    raw = 6'h03;
    wait_pulse(20, n);
    check("latency_second", 32'(n), 32'(D + 2));
    check("overrun_set", 32'({sif.snap_valid, sif.snap_data, over}), 32'({1'b1, 6'h03, 1'b1}));
    $display("seq overrun: data=%h valid=%b overrun=%b", sif.snap_data, sif.snap_valid, over);
    fclr = 1'b1; tick(); fclr = 1'b0;
    check("overrun_clear", 32'({sif.snap_valid, over}), 32'({1'b1, 1'b0}));

    // Commit on the same edge as acceptance.
    raw = 6'h07;
    repeat (D + 1) tick();
    check("pre_accept", 32'({pulse, sif.snap_valid, sif.snap_data}), 32'({1'b0, 1'b1, 6'h03}));
    sif.snap_ready = 1'b1;
    tick();
    check("commit_accept", 32'({pulse, sif.snap_valid, sif.snap_data, over}), 32'({1'b1, 1'b1, 6'h07, 1'b0}));
    $display("seq accept-commit: data=%h valid=%b overrun=%b", sif.snap_data, sif.snap_valid, over);
    tick();
    check("accept_drop", 32'({sif.snap_valid, sif.snap_data}), 32'({1'b0, 6'h07}));
    tick();
    check("ready_idle", 32'({sif.snap_valid, sif.snap_data, pulse}), 32'({1'b0, 6'h07, 1'b0}));
    sif.snap_ready = 1'b0;

    // Two short bursts on bit 5.
    do_reset();
    seen = 1'b0;
    raw = 6'h20; repeat (2) begin tick(); seen |= pulse; end
    raw = 6'h00; repeat (4) begin tick(); seen |= pulse; end
    raw = 6'h20; repeat (2) begin tick(); seen |= pulse; end
    raw = 6'h00; repeat (6) begin tick(); seen |= pulse; end
    check("chatter_seq", 32'({stable, seen, chat}), 32'({6'h00, 1'b0, EXP_CHAT}));
    $display("seq chatter: chatter=%h stable=%h", chat, stable);
    fclr = 1'b1; tick(); fclr = 1'b0;
    check("chatter_clear", 32'(chat), 32'h0);

    // Asynchronous reset mid-debounce with a snapshot pending.
    do_reset();
    raw = 6'h01;
    wait_pulse(20, n);
    raw = 6'h03;
    repeat (4) tick();
    check("pre_reset_pending", 32'({sif.snap_valid, stable}), 32'({1'b1, 6'h01}));
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(outs()), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_pulse(20, n);
    check("post_reset_latency", 32'(n), 32'(D + 2));
    check("post_reset_data", 32'({stable, sif.snap_data}), 32'({6'h03, 6'h03}));
    $display("seq reset: relaunch latency=%0d data=%h", n, sif.snap_data);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    raw_r = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 6; i++) if ($urandom_range(0, 7) == 0) raw_r[i] = ~raw_r[i];
      rdy_r = ($urandom_range(0, 2) == 0);
      fc_r  = ($urandom_range(0, 19) == 0);
      raw = raw_r; sif.snap_ready = rdy_r; fclr = fc_r;
      if (m_valid && rdy_r && m_stable == m_data)
        $display("rand %0d snapshot accepted data=%h", c, m_data);
      tick();
      model_edge(raw_r, rdy_r, fc_r);
      check($sformatf("rand%0d", c), 32'(outs()),
            32'({m_stable, m_pulse, m_valid, m_data, m_over, m_chat}));
    end
    sif.snap_ready = 1'b0; fclr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sensor_debounce_sampler.md
SENSOR_DEBOUNCE_SAMPLER -- requirements
Module: sensor_debounce_sampler

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 50000, consecutive stable clocks needed to commit a change; legal range 2..65535.
REQ-002 Parameter: CHATTER_LIMIT, default 8, aborted debounce attempts per bit before the chatter flag sets; legal range 1..255.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sensor_raw  input  6  raw switch inputs: [0] low, [1] middle, [2] high, [3] umidadeDoSolo, [4] umidadeDoAr, [5] temperatura.
REQ-006 sensor_stable  output  6  debounced sensor vector, same bit map.
REQ-007 change_pulse  output  1  one-cycle pulse on the cycle sensor_stable updates.
REQ-008 snap_data  output  6  snapshot of sensor_stable offered to the consumer.
REQ-009 snap_valid  output  1  snapshot pending.
REQ-010 snap_ready  input  1  consumer accepts snapshot when high with snap_valid.
REQ-011 overrun  output  1  sticky: a pending snapshot was overwritten before acceptance.
REQ-012 flag_clear  input  1  synchronous clear of overrun and chatter.
REQ-013 chatter  output  6  sticky per-bit chatter flags.

Function
REQ-014 Each sensor_raw bit SHALL pass a 2-flop synchronizer before any other logic; sync output is s[i].
REQ-015 Per bit, a 16-bit counter SHALL increment each cycle s[i] != sensor_stable[i] and SHALL clear when s[i] == sensor_stable[i].
REQ-016 When the counter of bit i reaches DEBOUNCE_CYCLES-1 with s[i] still differing, sensor_stable[i] SHALL take s[i] on the next edge and the counter SHALL clear.
REQ-017 Latency: raw level held constant commits to sensor_stable exactly DEBOUNCE_CYCLES+2 rising edges after first sampled.
REQ-018 A raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change sensor_stable.
REQ-019 Multiple bits committing on the same edge SHALL update together and produce one change_pulse.
REQ-020 On any commit, snap_data SHALL load the new sensor_stable value and snap_valid SHALL be 1 on the same cycle change_pulse is 1.
REQ-021 snap_valid SHALL hold with snap_data unchanged until snap_valid && snap_ready, then deassert next edge unless a commit occurs the same edge.
REQ-022 Commit while snap_valid=1 and snap_ready=0: snap_data SHALL take the newest value, snap_valid stays 1, overrun SHALL set.
REQ-023 Commit coincident with acceptance: new value loaded, snap_valid stays 1, overrun SHALL NOT set.
REQ-024 snap_ready while snap_valid=0 SHALL have no effect.
REQ-025 flag_clear SHALL clear overrun and chatter on the next edge; a set event on the same edge SHALL win.
REQ-026 Counters SHALL saturate, never wrap.

Reset
REQ-027 rst_n low SHALL asynchronously force synchronizers, counters, sensor_stable=0, change_pulse=0, snap_data=0, snap_valid=0, overrun=0, chatter=0.
REQ-028 Reset release SHALL be sampled synchronously; first commit possible DEBOUNCE_CYCLES+2 edges after release.
REQ-029 Reset asserted mid-debounce or with snapshot pending SHALL discard that state without producing change_pulse.

Configuration
REQ-030 Macro SENSOR_CHATTER_DETECT_EN defined: per-bit 8-bit abort counter increments when the debounce counter clears from nonzero without committing, clears on commit, and chatter[i] sets when it reaches CHATTER_LIMIT.
REQ-031 Macro SENSOR_CHATTER_DETECT_EN undefined: abort counters absent, chatter port present and tied to 0; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4, CHATTER_LIMIT=2)
REQ-032 Reset, hold sensor_raw=6'b000111 -> sensor_stable=6'b000111, change_pulse and snap_valid high exactly 6 edges after first sample.
REQ-033 3-cycle pulse on sensor_raw[3] from stable 0 -> sensor_stable unchanged, no change_pulse, no snapshot.
REQ-034 snap_ready=0, two separate commits (000001 then 000011) -> snap_data=000011, snap_valid=1, overrun=1; flag_clear -> overrun=0.
REQ-035 Commit on same edge as snap_valid&&snap_ready -> snap_valid stays 1 with new data, overrun=0.
REQ-036 Macro defined: bit 5 toggled twice for 2-cycle bursts -> chatter=6'b100000, sensor_stable[5] unchanged; macro undefined -> chatter=0.
REQ-037 rst_n dropped at debounce count 2 with snap_valid=1 -> all outputs 0 immediately, no pulse after release until a fresh 6-edge debounce.
